cp0_irq_unit: RTL and testbench

- Coprocessor-0 interrupt and exception unit on the CPU side of the device bus.
- Consumes the level IRQ lines driven by memory-mapped devices (timer, etc.) through the bridge as HWInt[5:0]. Also consumes internal exception codes from the pipeline.
- Decides when the pipeline must be redirected to the handler, and records SR/Cause/EPC.
- Serves mfc0/mtc0 reads and writes, and leaves handler mode on eret.

---
 rtl/cp0_irq_unit_pkg.sv | 45 ++++
 rtl/cp0_irq_unit_if.sv | 20 ++
 rtl/cp0_irq_unit_int_arbiter.sv | 43 ++++
 rtl/cp0_irq_unit.sv | 137 +++++++++++++
 tb/tb_cp0_irq_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cp0_irq_unit_pkg.sv
// ---------------------------------------------------------------------------
// cp0_defs
//   Coprocessor-0 definitions shared by the CP0 interrupt/exception unit and
//   the pipeline exception-code generator.
//   Contents: CP0 register numbers, bit positions of the SR/Cause fields,
//   exception code constants, the two-state EXL encoding and a small
//   word-alignment helper.
// ---------------------------------------------------------------------------
package cp0_defs;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Field positions inside SR and Cause
  localparam int BIT_IM_HI  = 15;
  localparam int BIT_IM_LO  = 10;
  localparam int BIT_EXL    = 1;
  localparam int BIT_IE     = 0;
  localparam int BIT_BD     = 31;
  localparam int BIT_EXC_HI = 6;
  localparam int BIT_EXC_LO = 2;

  // Exception codes; EXC_INT doubles as "no exception" on the pipeline side
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // The unit is either running normal code or inside a handler; the encoding
  // is chosen so that the state value is exactly the SR.EXL bit.
  typedef enum logic {
    CP0_NORMAL  = 1'b0,
    CP0_HANDLER = 1'b1
  } cp0_state_e;

  // Clear the two low address bits (EPC is always word aligned)
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/cp0_irq_unit_if.sv
// ---------------------------------------------------------------------------
// cp0_irq_unit_if
//   mfc0/mtc0 access bus of the CP0 interrupt/exception unit.
//   A1   : mfc0 read register number
//   A2   : mtc0 write register number
//   DIn  : mtc0 write data
//   WE   : mtc0 write enable
//   DOut : mfc0 read data (combinational from A1)
//   master = pipeline side, slave = CP0 side.
// ---------------------------------------------------------------------------
interface cp0_irq_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] DOut;

  modport master (output A1, A2, DIn, WE, input DOut);
  modport slave  (input A1, A2, DIn, WE, output DOut);
endinterface

// File: rtl/cp0_irq_unit_int_arbiter.sv
// ---------------------------------------------------------------------------
// cp0_int_arbiter
//   Combinational decision logic of the CP0 unit: decides whether the
//   M-stage instruction is redirected to the handler and what gets recorded.
//   hw_int       : live device IRQ levels
//   im, ie, exl  : registered SR fields
//   exc_code     : M-stage exception code (0 = none)
//   pc, bd       : M-stage PC and branch-delay-slot flag
//   int_req      : redirect the pipeline this cycle
//   sel_exc_code : code to record in Cause (interrupt wins over exception)
//   sel_epc      : word-aligned restart address to record in EPC
// ---------------------------------------------------------------------------
module cp0_int_arbiter
  import cp0_defs::*;
#(
  parameter int NUM_HWINT = 6
) (
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic [NUM_HWINT-1:0] im,
  input  logic                 ie,
  input  logic                 exl,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          pc,
  input  logic                 bd,
  output logic                 int_req,
  output logic [4:0]           sel_exc_code,
  output logic [31:0]          sel_epc
);

  logic int_hit;
  logic exc_hit;

  // Both sources are blocked while a handler runs (EXL=1). A delay-slot
  // instruction restarts at its branch, hence PC-4.
  always_comb begin
    int_hit      = (|(hw_int & im)) & ie & ~exl;
    exc_hit      = (exc_code != EXC_INT) & ~exl;
    int_req      = int_hit | exc_hit;
    sel_exc_code = int_hit ? EXC_INT : exc_code;
    sel_epc      = word_align(bd ? (pc - 32'd4) : pc);
  end

endmodule

// File: rtl/cp0_irq_unit.sv
// ---------------------------------------------------------------------------
// cp0_irq_unit
//   Coprocessor-0 interrupt and exception unit. Watches device IRQ levels and
//   pipeline exception codes, redirects the pipeline to the handler, records
//   SR/Cause/EPC, serves mfc0/mtc0 and leaves handler mode on eret.
//   clk     : system clock, all state changes on the rising edge
//   reset   : asynchronous, active-low reset
//   bus     : mfc0/mtc0 access (A1, A2, DIn, WE, DOut)
//   PC, BD  : M-stage PC and branch-delay-slot flag
//   ExcCode : M-stage exception code, 0 = none
//   EXLClr  : eret in the M stage
//   HWInt   : device IRQ levels (bit 2 timer 0, bit 3 timer 1)
//   IntReq  : redirect the pipeline to the handler this cycle
//   EPC     : current EPC, used by eret
// ---------------------------------------------------------------------------
module cp0_irq_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID      = 32'h2020_0329,
  parameter int          NUM_HWINT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_irq_unit_if.slave        bus,
  input  logic [31:0]          PC,
  input  logic                 BD,
  input  logic [4:0]           ExcCode,
  input  logic                 EXLClr,
  input  logic [NUM_HWINT-1:0] HWInt,
  output logic                 IntReq,
  output logic [31:0]          EPC
);

  cp0_state_e           state_q;
  cp0_state_e           state_d;
  logic [NUM_HWINT-1:0] im_q;
  logic                 ie_q;
  logic [NUM_HWINT-1:0] ip_q;
  logic                 cause_bd_q;
  logic [4:0]           exc_code_q;
  logic [31:0]          epc_q;

  logic                 exl;
  logic                 wr_sr;
  logic                 wr_epc;
  logic [4:0]           sel_exc_code;
  logic [31:0]          sel_epc;

  assign exl = (state_q == CP0_HANDLER);

  // A redirect in the same cycle discards the mtc0 completely
  assign wr_sr  = bus.WE & (bus.A2 == REG_SR)  & ~IntReq;
  assign wr_epc = bus.WE & (bus.A2 == REG_EPC) & ~IntReq;

  cp0_int_arbiter #(
    .NUM_HWINT (NUM_HWINT)
  ) u_arbiter (
    .hw_int       (HWInt),
    .im           (im_q),
    .ie           (ie_q),
    .exl          (exl),
    .exc_code     (ExcCode),
    .pc           (PC),
    .bd           (BD),
    .int_req      (IntReq),
    .sel_exc_code (sel_exc_code),
    .sel_epc      (sel_epc)
  );

  // EXL state register; reset drops straight back to NORMAL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CP0_NORMAL;
    else        state_q <= state_d;
  end

  // Next EXL: a redirect always enters the handler. Otherwise an mtc0 to SR
  // may set or clear EXL, but eret has the last word and forces NORMAL.
  always_comb begin
    state_d = state_q;
    if (IntReq) begin
      state_d = CP0_HANDLER;
    end else begin
      if (wr_sr)  state_d = cp0_state_e'(bus.DIn[BIT_EXL]);
      if (EXLClr) state_d = CP0_NORMAL;
    end
  end

  // SR/Cause/EPC storage. IP samples HWInt every cycle regardless of EXL or
  // IM, so software always sees the levels one cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      ie_q       <= 1'b0;
      ip_q       <= '0;
      cause_bd_q <= 1'b0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
    end else begin
      ip_q <= HWInt;
      if (IntReq) begin
        cause_bd_q <= BD;
        exc_code_q <= sel_exc_code;
        epc_q      <= sel_epc;
      end else begin
        if (wr_sr) begin
          im_q <= bus.DIn[BIT_IM_LO +: NUM_HWINT];
          ie_q <= bus.DIn[BIT_IE];
        end
        if (wr_epc) epc_q <= word_align(bus.DIn);
      end
    end
  end

  assign EPC = epc_q;

  // mfc0 read mux over registered values only; a same-cycle mtc0 is not
  // bypassed, so the old value is returned.
  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      REG_SR: begin
        bus.DOut[BIT_IM_LO +: NUM_HWINT] = im_q;
        bus.DOut[BIT_EXL]                = exl;
        bus.DOut[BIT_IE]                 = ie_q;
      end
      REG_CAUSE: begin
        bus.DOut[BIT_BD]                   = cause_bd_q;
        bus.DOut[BIT_IM_LO +: NUM_HWINT]   = ip_q;
        bus.DOut[BIT_EXC_HI:BIT_EXC_LO]    = exc_code_q;
      end
      REG_EPC:  bus.DOut = epc_q;
      REG_PRID: bus.DOut = PRID;
      default:  bus.DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_unit.sv
// ---------------------------------------------------------------------------
// tb_cp0_irq_unit
//   Self-checking bench for cp0_irq_unit: a table of one-cycle vectors with
//   hand-computed IntReq/read/EPC values, followed by a hand-written
//   asynchronous-reset-in-handler sequence.
// ---------------------------------------------------------------------------
module tb_cp0_irq_unit;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC;

  int checks;
  int failures;

  cp0_irq_unit_if bus_if ();

  cp0_irq_unit dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .PC      (PC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .EXLClr  (EXLClr),
    .HWInt   (HWInt),
    .IntReq  (IntReq),
    .EPC     (EPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        exl_clr;
    logic [5:0]  hw;
    logic [4:0]  a1;
    logic        exp_int_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input string name, input logic we, input logic [4:0] a2,
                                 input logic [31:0] din, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] exc, input logic exl_clr, input logic [5:0] hw,
                                 input logic [4:0] a1, input logic exp_int_req,
                                 input logic [31:0] exp_dout, input logic [31:0] exp_epc);
    vec_t v;
    v.name = name; v.we = we; v.a2 = a2; v.din = din; v.pc = pc; v.bd = bd;
    v.exc = exc; v.exl_clr = exl_clr; v.hw = hw; v.a1 = a1;
    v.exp_int_req = exp_int_req; v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus_if.WE  = v.we;
    bus_if.A2  = v.a2;
    bus_if.DIn = v.din;
    bus_if.A1  = v.a1;
    PC         = v.pc;
    BD         = v.bd;
    ExcCode    = v.exc;
    EXLClr     = v.exl_clr;
    HWInt      = v.hw;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic readCheck(input string name, input logic [4:0] a1, input logic [31:0] expected);
    bus_if.A1 = a1;
    #1;
    checkOutput(name, bus_if.DOut, expected);
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    applyStimulus(mkVec("init", 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0, 0));

    // Reset state
    #12;
    checkOutput("rst_intreq", {31'b0, IntReq}, 32'h0);
    checkOutput("rst_epc_port", EPC, 32'h0);
    readCheck("rst_sr", 5'd12, 32'h0);
    readCheck("rst_cause", 5'd13, 32'h0);
    readCheck("rst_epc", 5'd14, 32'h0);
    readCheck("rst_prid", 5'd15, 32'h2020_0329);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    //                  name            we a2  din             pc             bd exc clr hw         a1 irq dout            epc
    vecs.push_back(mkVec("sr_w401",      1, 12, 32'h0000_0401, 32'h0000_3010, 0, 0,  0, 6'b000100, 12, 0, 32'h0000_0401, 32'h0));
    vecs.push_back(mkVec("ip_masked0",   0, 0,  32'h0,         32'h0000_3010, 0, 0,  0, 6'b000100, 13, 0, 32'h0000_1000, 32'h0));
    vecs.push_back(mkVec("sr_w801",      1, 12, 32'h0000_0801, 32'h0000_3010, 0, 0,  0, 6'b000100, 12, 0, 32'h0000_0801, 32'h0));
    vecs.push_back(mkVec("ip_masked1",   0, 0,  32'h0,         32'h0000_3010, 0, 0,  0, 6'b000100, 13, 0, 32'h0000_1000, 32'h0));
    vecs.push_back(mkVec("sr_w1001",     1, 12, 32'h0000_1001, 32'h0000_3010, 0, 0,  0, 6'b000100, 12, 0, 32'h0000_1001, 32'h0));
    vecs.push_back(mkVec("timer_irq",    0, 0,  32'h0,         32'h0000_3010, 0, 0,  0, 6'b000100, 14, 1, 32'h0000_3010, 32'h0000_3010));
    vecs.push_back(mkVec("hdl_sr",       0, 0,  32'h0,         32'h0000_3014, 0, 0,  0, 6'b000100, 12, 0, 32'h0000_1003, 32'h0000_3010));
    vecs.push_back(mkVec("hdl_cause",    0, 0,  32'h0,         32'h0000_3014, 0, 0,  0, 6'b000100, 13, 0, 32'h0000_1000, 32'h0000_3010));
    vecs.push_back(mkVec("eret1",        0, 0,  32'h0,         32'h0000_3014, 0, 0,  1, 6'b000100, 12, 0, 32'h0000_1001, 32'h0000_3010));
    vecs.push_back(mkVec("retrigger",    0, 0,  32'h0,         32'h0000_3040, 0, 0,  0, 6'b000100, 14, 1, 32'h0000_3040, 32'h0000_3040));
    vecs.push_back(mkVec("eret2",        0, 0,  32'h0,         32'h0000_3044, 0, 0,  1, 6'b000000, 12, 0, 32'h0000_1001, 32'h0000_3040));
    vecs.push_back(mkVec("ds_exc",       0, 0,  32'h0,         32'h0000_3024, 1, 12, 0, 6'b000000, 13, 1, 32'h8000_0030, 32'h0000_3020));
    vecs.push_back(mkVec("ds_epc",       0, 0,  32'h0,         32'h0000_3024, 0, 0,  0, 6'b000000, 14, 0, 32'h0000_3020, 32'h0000_3020));
    vecs.push_back(mkVec("exc_in_exl",   0, 0,  32'h0,         32'h0000_3028, 0, 4,  0, 6'b000000, 13, 0, 32'h8000_0030, 32'h0000_3020));
    vecs.push_back(mkVec("eret_mtc0_sr", 1, 12, 32'h0000_1003, 32'h0000_3028, 0, 0,  1, 6'b000000, 12, 0, 32'h0000_1001, 32'h0000_3020));
    vecs.push_back(mkVec("cause_wr_ign", 1, 13, 32'hFFFF_FFFF, 32'h0000_3028, 0, 0,  0, 6'b000000, 13, 0, 32'h8000_0030, 32'h0000_3020));
    vecs.push_back(mkVec("epc_wr",       1, 14, 32'h0000_5003, 32'h0000_3028, 0, 0,  0, 6'b000000, 14, 0, 32'h0000_5000, 32'h0000_5000));
    vecs.push_back(mkVec("simul_evt",    1, 14, 32'h0000_5000, 32'h0000_3100, 0, 10, 0, 6'b000100, 14, 1, 32'h0000_3100, 32'h0000_3100));
    vecs.push_back(mkVec("simul_cause",  0, 0,  32'h0,         32'h0000_3100, 0, 0,  0, 6'b000100, 13, 0, 32'h0000_1000, 32'h0000_3100));
    vecs.push_back(mkVec("prid_wr_ign",  1, 15, 32'h0,         32'h0000_3100, 0, 0,  0, 6'b000100, 15, 0, 32'h2020_0329, 32'h0000_3100));
    vecs.push_back(mkVec("unmapped_rd",  0, 0,  32'h0,         32'h0000_3100, 0, 0,  0, 6'b000100, 7,  0, 32'h0,         32'h0000_3100));

    // Each vector: drive, check IntReq before the edge, check read/EPC after it
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, "_intreq"}, {31'b0, IntReq}, {31'b0, vecs[i].exp_int_req});
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_dout"}, bus_if.DOut, vecs[i].exp_dout);
      checkOutput({vecs[i].name, "_epc"}, EPC, vecs[i].exp_epc);
    end

    // Asynchronous reset while in the handler, timer still asserting
    applyStimulus(mkVec("idle", 0, 0, 0, 32'h0000_3200, 0, 0, 0, 6'b000100, 12, 0, 0, 0));
    #1;
    checkOutput("pre_rst_sr", bus_if.DOut, 32'h0000_1003);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_intreq", {31'b0, IntReq}, 32'h0);
    checkOutput("arst_epc_port", EPC, 32'h0);
    readCheck("arst_sr", 5'd12, 32'h0);
    readCheck("arst_cause", 5'd13, 32'h0);
    readCheck("arst_epc", 5'd14, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post_rst_intreq%0d", c), {31'b0, IntReq}, 32'h0);
    end

    // Reprogramming SR re-enables the still-high timer IRQ
    applyStimulus(mkVec("reprog", 1, 12, 32'h0000_1001, 32'h0000_3200, 0, 0, 0, 6'b000100, 12, 0, 0, 0));
    #1;
    checkOutput("reprog_before", {31'b0, IntReq}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(mkVec("idle2", 0, 0, 0, 32'h0000_3200, 0, 0, 0, 6'b000100, 12, 0, 0, 0));
    #1;
    checkOutput("reprog_intreq", {31'b0, IntReq}, 32'h1);
    checkOutput("reprog_sr", bus_if.DOut, 32'h0000_1001);
    @(posedge clk);
    #1;
    checkOutput("reprog_epc", EPC, 32'h0000_3200);
    checkOutput("reprog_exl", bus_if.DOut, 32'h0000_1003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
